// File: rtl/timer_bank.sv
// Bank of independent down-counting timer channels behind a word-addressed slave port.
// Each channel: CTRL (EN, MODE, IM), PRESET, read-only COUNT and a sticky PENDING flag.
module timer_bank #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h7F00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Addr,
  input  logic                WE,
  input  logic [31:0]         Din,
  output logic                hit,
  output logic [31:0]         Dout,
  output logic [CHANNELS-1:0] irq,
  output logic                irq_any
);

  localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [31:0] Span = 32'(CHANNELS * 16);

  typedef enum logic [1:0] {StIdle, StCnt, StDone} state_e;

  // Register state
  logic [CHANNELS-1:0] r_en, r_im, r_pend;
  logic [1:0]          r_mode   [CHANNELS];
  logic [WIDTH-1:0]    r_preset [CHANNELS];
  logic [WIDTH-1:0]    r_count  [CHANNELS];
  state_e              r_state  [CHANNELS];

  // Next-state values
  logic [CHANNELS-1:0] w_en_nxt, w_im_nxt, w_pend_nxt, w_pend_set;
  logic [1:0]          w_mode_nxt   [CHANNELS];
  logic [WIDTH-1:0]    w_preset_nxt [CHANNELS];
  logic [WIDTH-1:0]    w_count_nxt  [CHANNELS];
  state_e              w_state_nxt  [CHANNELS];

  logic [31:0]    w_off;
  logic [ChW-1:0] w_chan;
  logic [1:0]     w_reg;
  logic           w_wr;
  logic [31:0]    w_rd;

  // Window decode: the unsigned offset compare also rejects addresses below the base
  assign w_off  = Addr - BASE_ADDR;
  assign hit    = (w_off < Span);
  assign w_chan = w_off[4 +: ChW];
  assign w_reg  = Addr[3:2];
  assign w_wr   = hit & WE;

  // Per-channel FSM step followed by the software write; software has the last word
  // except that a hardware PENDING set beats a same-cycle write-1-clear.
  always_comb begin
    w_en_nxt   = r_en;
    w_im_nxt   = r_im;
    w_pend_nxt = r_pend;
    w_pend_set = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_mode_nxt[i]   = r_mode[i];
      w_preset_nxt[i] = r_preset[i];
      w_count_nxt[i]  = r_count[i];
      w_state_nxt[i]  = r_state[i];

      unique case (r_state[i])
        StIdle: begin
          if (r_en[i]) begin
            w_count_nxt[i] = r_preset[i];
            w_state_nxt[i] = StCnt;
          end
        end
        StCnt: begin
          if (!r_en[i]) begin
            w_state_nxt[i] = StIdle;
          end else if (r_count[i] > WIDTH'(1)) begin
            w_count_nxt[i] = r_count[i] - WIDTH'(1);
          end else begin
            w_count_nxt[i] = '0;
            w_pend_set[i]  = 1'b1;
            w_state_nxt[i] = StDone;
          end
        end
        StDone: begin
          // Auto-reload re-enters through IDLE so every period repeats the
          // first-expiry timing: reload edge, load edge, then the count-down.
          w_state_nxt[i] = StIdle;
          if (r_en[i] && (r_mode[i] == 2'b01)) begin
            w_count_nxt[i] = r_preset[i];
          end else if (r_en[i]) begin
            w_en_nxt[i] = 1'b0;
          end
        end
        default: w_state_nxt[i] = StIdle;
      endcase

      if (w_wr && (w_chan == ChW'(i))) begin
        unique case (w_reg)
          2'd0: begin
            w_en_nxt[i]   = Din[0];
            w_mode_nxt[i] = Din[2:1];
            w_im_nxt[i]   = Din[3];
          end
          2'd1: w_preset_nxt[i] = Din[WIDTH-1:0];
          2'd3: if (Din[0]) w_pend_nxt[i] = 1'b0;
          default: ;
        endcase
      end

      if (w_pend_set[i]) w_pend_nxt[i] = 1'b1;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en   <= '0;
      r_im   <= '0;
      r_pend <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_mode[i]   <= 2'b00;
        r_preset[i] <= '0;
        r_count[i]  <= '0;
        r_state[i]  <= StIdle;
      end
    end else begin
      r_en   <= w_en_nxt;
      r_im   <= w_im_nxt;
      r_pend <= w_pend_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        r_mode[i]   <= w_mode_nxt[i];
        r_preset[i] <= w_preset_nxt[i];
        r_count[i]  <= w_count_nxt[i];
        r_state[i]  <= w_state_nxt[i];
      end
    end
  end

  // Read mux, zero-extended to 32 bits
  always_comb begin
    w_rd = '0;
    if (hit) begin
      unique case (w_reg)
        2'd0: w_rd[3:0] = {r_im[w_chan], r_mode[w_chan], r_en[w_chan]};
        2'd1: w_rd[WIDTH-1:0] = r_preset[w_chan];
        2'd2: w_rd[WIDTH-1:0] = r_count[w_chan];
        default: w_rd[0] = r_pend[w_chan];
      endcase
    end
  end

  assign Dout    = w_rd;
  assign irq     = r_pend & r_im;
  assign irq_any = |irq;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: main 4x32 instance plus a 1x8 instance for width truncation.
module tb_timer_bank;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic        hit;
  logic [31:0] Dout;
  logic [3:0]  irq;
  logic        irq_any;
  logic        s_hit;
  logic [31:0] s_dout;
  logic [0:0]  s_irq;
  logic        s_irq_any;

  int checks;
  int failures;

  timer_bank #(.CHANNELS(4), .WIDTH(32), .BASE_ADDR(32'h7F00)) dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .hit     (hit),
    .Dout    (Dout),
    .irq     (irq),
    .irq_any (irq_any)
  );

  timer_bank #(.CHANNELS(1), .WIDTH(8), .BASE_ADDR(32'h7F00)) dut_small (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .hit     (s_hit),
    .Dout    (s_dout),
    .irq     (s_irq),
    .irq_any (s_irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ra(input int ch, input int r);
    return 32'h7F00 + 32'(ch * 16 + r * 4);
  endfunction

  // One write: set up at negedge, commit at posedge, return at posedge+1
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = Dout;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    wr(ra(0, 1), 32'd10);
    wr(ra(0, 0), 32'h9);
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    rd(ra(0, 2), v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_count got=%0h exp=0", v); end
    rd(ra(0, 0), v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%0h exp=0", v); end
    rd(ra(0, 1), v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_preset got=%0h exp=0", v); end
    checks++;
    if (irq !== 4'b0 || irq_any !== 1'b0) begin
      failures++; $display("FAIL reset_irq got=%b/%b exp=0000/0", irq, irq_any);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) tick();
    rd(ra(0, 2), v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL post_reset_count got=%0h exp=0", v); end
  endtask

  task automatic test_one_shot();
    logic [31:0] v, st;
    wr(ra(1, 1), 32'd5);
    wr(ra(1, 0), 32'h9);
    for (int k = 1; k <= 6; k++) begin
      tick();
      rd(ra(1, 2), v);
      rd(ra(1, 3), st);
      checks++;
      if (v !== 32'(6 - k)) begin
        failures++; $display("FAIL oneshot_count edge=%0d got=%0d exp=%0d", k, v, 6 - k);
      end
      checks++;
      if (st[0] !== (k == 6) || irq[1] !== (k == 6)) begin
        failures++; $display("FAIL oneshot_pend edge=%0d got=%b/%b exp=%b", k, st[0], irq[1], k == 6);
      end
    end
    tick();
    rd(ra(1, 0), v);
    checks++; if (v !== 32'h8) begin failures++; $display("FAIL oneshot_ctrl got=%0h exp=8", v); end
    checks++; if (irq !== 4'b0010) begin failures++; $display("FAIL oneshot_sticky got=%b exp=0010", irq); end
    wr(ra(1, 3), 32'h1);
    checks++; if (irq !== 4'b0000) begin failures++; $display("FAIL oneshot_w1c got=%b exp=0000", irq); end
  endtask

  task automatic test_auto_reload();
    wr(ra(2, 1), 32'd3);
    wr(ra(2, 0), 32'hB);
    for (int e = 1; e <= 14; e++) begin
      if (e == 5 || e == 10) wr(ra(2, 3), 32'h1);
      else tick();
      checks++;
      if (irq[2] !== (e == 4 || e == 9 || e == 14)) begin
        failures++; $display("FAIL autoreload_irq edge=%0d got=%b exp=%b", e, irq[2],
                             (e == 4 || e == 9 || e == 14));
      end
    end
    wr(ra(2, 0), 32'h0);
    tick();
    wr(ra(2, 3), 32'h1);
    checks++; if (irq !== 4'b0) begin failures++; $display("FAIL autoreload_stop got=%b exp=0000", irq); end
  endtask

  task automatic test_race();
    logic [31:0] v;
    wr(ra(0, 1), 32'd2);
    wr(ra(0, 0), 32'h9);
    tick();
    tick();
    wr(ra(0, 3), 32'h1);
    rd(ra(0, 3), v);
    checks++;
    if (v[0] !== 1'b1 || irq[0] !== 1'b1) begin
      failures++; $display("FAIL race_set_wins got=%b/%b exp=1/1", v[0], irq[0]);
    end
    tick();
    wr(ra(0, 3), 32'h1);
    rd(ra(0, 3), v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL race_clear got=%0h exp=0", v); end
    // CTRL write coinciding with the one-shot auto-clear in DONE
    wr(ra(0, 1), 32'd1);
    wr(ra(0, 0), 32'h9);
    tick();
    tick();
    wr(ra(0, 0), 32'h9);
    rd(ra(0, 0), v);
    checks++; if (v !== 32'h9) begin failures++; $display("FAIL ctrl_sw_wins got=%0h exp=9", v); end
    wr(ra(0, 0), 32'h0);
    repeat (3) tick();
    wr(ra(0, 3), 32'h1);
    // Masked channel: PENDING sets, irq stays low
    wr(ra(0, 0), 32'h1);
    tick();
    tick();
    rd(ra(0, 3), v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL masked_pend got=%0h exp=1", v); end
    checks++;
    if (irq !== 4'b0 || irq_any !== 1'b0) begin
      failures++; $display("FAIL masked_irq got=%b/%b exp=0000/0", irq, irq_any);
    end
    tick();
    wr(ra(0, 3), 32'h1);
  endtask

  task automatic test_edges();
    logic [31:0] v;
    wr(ra(3, 1), 32'd0);
    wr(ra(3, 0), 32'h9);
    tick();
    rd(ra(3, 3), v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL preset0_e1 got=%0h exp=0", v); end
    tick();
    rd(ra(3, 3), v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL preset0_e2 got=%0h exp=1", v); end
    tick();
    wr(ra(3, 3), 32'h1);
    // Clear EN mid-count
    wr(ra(3, 1), 32'd10);
    wr(ra(3, 0), 32'h1);
    repeat (3) tick();
    rd(ra(3, 2), v);
    checks++; if (v !== 32'd8) begin failures++; $display("FAIL encl_pre got=%0d exp=8", v); end
    wr(ra(3, 0), 32'h0);
    rd(ra(3, 2), v);
    checks++; if (v !== 32'd7) begin failures++; $display("FAIL encl_at got=%0d exp=7", v); end
    repeat (3) tick();
    rd(ra(3, 2), v);
    checks++; if (v !== 32'd7) begin failures++; $display("FAIL encl_frozen got=%0d exp=7", v); end
    // PRESET rewritten mid-count only affects the next load
    wr(ra(3, 1), 32'd4);
    wr(ra(3, 0), 32'h3);
    tick();
    tick();
    wr(ra(3, 1), 32'd9);
    rd(ra(3, 2), v);
    checks++; if (v !== 32'd2) begin failures++; $display("FAIL presetmid_count got=%0d exp=2", v); end
    tick();
    tick();
    rd(ra(3, 2), v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL presetmid_exp got=%0d exp=0", v); end
    tick();
    rd(ra(3, 2), v);
    checks++; if (v !== 32'd9) begin failures++; $display("FAIL presetmid_reload got=%0d exp=9", v); end
    wr(ra(3, 0), 32'h0);
    tick();
    wr(ra(3, 3), 32'h1);
  endtask

  task automatic test_decode();
    logic [31:0] v;
    Addr = 32'h7F40;
    #1;
    checks++;
    if (hit !== 1'b0 || Dout !== 32'h0) begin
      failures++; $display("FAIL decode_above got=%b/%0h exp=0/0", hit, Dout);
    end
    Addr = 32'h7EFC;
    #1;
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL decode_below got=%b exp=0", hit); end
    Addr = 32'h7F3C;
    #1;
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL decode_top got=%b exp=1", hit); end
    wr(32'h7F40, 32'hFFFF_FFFF);
    rd(ra(0, 0), v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL decode_nowrite_ctrl got=%0h exp=0", v); end
    rd(ra(3, 1), v);
    checks++; if (v !== 32'd9) begin failures++; $display("FAIL decode_nowrite_preset got=%0h exp=9", v); end
    wr(32'h7F08, 32'h55);
    rd(ra(0, 2), v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL count_ro got=%0h exp=0", v); end
    wr(32'h7F04, 32'h1FF);
    Addr = 32'h7F04;
    #1;
    checks++;
    if (s_hit !== 1'b1 || s_dout !== 32'hFF) begin
      failures++; $display("FAIL narrow_preset got=%b/%0h exp=1/ff", s_hit, s_dout);
    end
    Addr = 32'h7F10;
    #1;
    checks++; if (s_hit !== 1'b0) begin failures++; $display("FAIL narrow_window got=%b exp=0", s_hit); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    Addr     = 32'h0;
    WE       = 1'b0;
    Din      = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_race();
    test_edges();
    test_decode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
